lut_cfg_ctrl: RTL

- Controller sequencing the LUT configuration memory that feeds the mux_tree datapath.
- Programming phase: streams DEPTH = 2^CONTROL_WIDTH configuration words into the memory via a valid/ready handshake.
- Evaluation phase: accepts select requests, reads the addressed entry and returns it on a valid/ready result port.
- Sits between the configuration/host side and the external synchronous LUT memory; the memory is instantiated in the parent.

---
 rtl/lut_pkg.sv | 16 +
 rtl/lut_cfg_ctrl.sv | 79 +++++++
 2 files changed

// File: rtl/lut_pkg.sv
// lut_pkg: shared state encoding and depth helper for the LUT configuration controller
package lut_pkg;
    typedef enum logic [2:0] {
        UNCONF  = 3'd0,
        PROG    = 3'd1,
        READY   = 3'd2,
        FETCH   = 3'd3,
        CAPTURE = 3'd4,
        RESP    = 3'd5
    } lut_cfg_state_e;
    localparam int DEFAULT_CONTROL_WIDTH = 4;
    localparam int DEPTH = 1 << DEFAULT_CONTROL_WIDTH;
    function automatic int lut_depth(input int control_width);
        return 1 << control_width;
    endfunction
endpackage

// File: rtl/lut_cfg_ctrl.sv
// lut_cfg_ctrl: programs the external LUT memory from a config stream, then serves select lookups
module lut_cfg_ctrl
    import lut_pkg::*;
#(
    parameter int DATA_WIDTH    = 4,
    parameter int CONTROL_WIDTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cfg_start,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [DATA_WIDTH-1:0]    cfg_data,
    output logic                     cfg_done,
    input  logic                     eval_valid,
    output logic                     eval_ready,
    input  logic [CONTROL_WIDTH-1:0] eval_sel,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [DATA_WIDTH-1:0]    res_data,
    output logic                     mem_we,
    output logic [CONTROL_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);
    localparam logic [CONTROL_WIDTH-1:0] LAST = CONTROL_WIDTH'(lut_depth(CONTROL_WIDTH) - 1);
    lut_cfg_state_e state;
    logic [CONTROL_WIDTH-1:0] cnt;
    logic cfg_beat, eval_hs;
    always_comb begin
        cfg_ready  = state == PROG;
        eval_ready = (state == READY) & ~cfg_start;
        cfg_beat   = cfg_valid & cfg_ready;
        eval_hs    = eval_valid & eval_ready;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= UNCONF;
            cnt       <= '0;
            cfg_done  <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we   <= cfg_beat;
            cfg_done <= cfg_beat && cnt == LAST;
            if (cfg_beat) begin
                mem_addr  <= cnt;
                mem_wdata <= cfg_data;
                cnt       <= cnt + 1'b1;
            end
            if (eval_hs) mem_addr <= eval_sel;
            case (state)
                UNCONF: if (cfg_start) begin
                    state <= PROG;
                    cnt   <= '0;
                end
                PROG: if (cfg_beat && cnt == LAST) state <= READY;
                READY: if (cfg_start) begin
                    state <= PROG;
                    cnt   <= '0;
                end else if (eval_valid) state <= FETCH;
                FETCH: state <= CAPTURE;
                CAPTURE: begin
                    res_data  <= mem_rdata;
                    res_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: if (res_ready) begin
                    res_valid <= 1'b0;
                    state     <= READY;
                end
                default: state <= UNCONF;
            endcase
        end
    end
endmodule
